dla_host_seq: RTL and testbench
===============================

Name: dla_host_seq

Overview:
- Initiator-side sequencer that drives the DLA's memory-mapped write and read ports; it is the other end of the DLA slave interface.
- Accepts commands from the CPU-side wrapper: load weights, IFM0 or IFM1; write op_config; wait for the interrupt and clear it; read back output psums.
- Write payload is consumed from an input valid/ready stream. Read results are returned on an output valid/ready stream.
- Sits between the DLA wrapper/DMA and the DLA, in the DLA clock domain.

Parameters:
- BW, 32, data/address width; matches `BANDWIDTH.
- LEN_W, 16, width of the command word count.
- RD_LAT, 1, cycles from dla_r_addr valid to dla_r_data valid; SRAM/psum read latency; legal range 1..3.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  3  0=LD_WEIGHT, 1=LD_IFM0, 2=LD_IFM1, 3=CFG, 4=WAIT_INT, 5=RD_OUT; 6,7 reserved.
- cmd_base  in  BW  first word address.
- cmd_len  in  LEN_W  number of words.
- in_valid / in_ready / in_data  in/out/in  1/1/BW  write payload stream.
- out_valid / out_ready / out_data  out/in/out  1/1/BW  read-back stream.
- dla_w_addr  out  BW  DLA write address.
- dla_w_data  out  BW  DLA write data.
- dla_r_addr  out  BW  DLA read address.
- dla_config_w_en  out  3  active high; [0]/[1] op_config words, [2] interrupt register.
- dla_ifm0_w_en, dla_ifm1_w_en  out  4  active low; idle value 4'hF.
- dla_weight_w_en  out  4  active high; idle value 4'h0.
- dla_r_data  in  BW  DLA read data.
- dla_inpt  in  1  DLA interrupt, level, already synchronous to clk.
- busy  out  1  state != IDLE.
- cmd_err  out  1  one-cycle pulse on a reserved op.

Behaviour:
- Reset (async assert, deassertion sampled on clk): state=IDLE, all counters 0.
  - Outputs at reset: addresses/data 0, ifm w_en 4'hF, weight/config w_en 0, out_valid 0, in_ready 0, busy 0, cmd_err 0.
  - Reset mid-command abandons it and drops out_valid immediately; no partial-write recovery.
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD, WAIT_INT, CLR_INT.
- IDLE: on cmd_valid&&cmd_ready, latch base→addr register and len→remaining counter, then dispatch.
  - cmd_len==0 on any load/read op: stay IDLE, no DLA access.
  - Reserved op: pulse cmd_err, stay IDLE.
- WRITE (LD_* and CFG):
  - in_ready=1. Each in_valid&&in_ready beat drives a single-cycle write the same cycle: dla_w_addr=addr, dla_w_data=in_data, enable asserted for that cycle only.
  - Then addr+=1 and remaining-=1; at 0 go to IDLE. No write when in_valid=0.
  - Enables per op: LD_WEIGHT → weight_w_en=4'hF; LD_IFM0/1 → the matching ifm w_en=4'h0 and the other stays 4'hF.
  - IFM/weight loads are full-word writes only.
  - CFG: cmd_len forced to 2. Word k drives dla_config_w_en = one-hot bit k; cmd_base is ignored and dla_w_addr=k.
- WAIT_INT: wait for dla_inpt==1, then go to CLR_INT.
- CLR_INT: one cycle with dla_config_w_en=3'b100 and dla_w_data=0, then IDLE. WAIT_INT to IDLE takes ≥2 cycles.
- Read path (RD_OUT), RD_ISSUE → RD_WAIT → RD_HOLD:
  - RD_ISSUE: drive dla_r_addr=addr for one cycle.
  - RD_WAIT: hold dla_r_addr stable and count RD_LAT cycles, then capture dla_r_data into out_data and set out_valid.
  - RD_HOLD: hold out_data stable while out_valid&&!out_ready. On handshake: addr+=1, remaining-=1; go to RD_ISSUE, or IDLE when remaining hits 0.
  - dla_r_addr holds its last value between reads.
  - Throughput is one word per RD_LAT+2 cycles with out_ready held high.
- Address increment wraps modulo 2^BW; no error is flagged.
- The command is not accepted while busy; the cmd fields are sampled only at acceptance.
- At most one write enable group is active in any cycle. Writes and reads never overlap.

Decomposition:
- Package dla_host_pkg holds:
  - enum cmd_op_e (values above);
  - enum state_e;
  - constants IFM_WEN_IDLE=4'hF, IFM_WEN_ALL=4'h0, WEI_WEN_ALL=4'hF, CFG_WEN_INPT=3'b100.
- Optional sub-module dla_rd_lat_cnt: the RD_LAT down-counter plus capture register. Everything else lives in one FSM module.

Test Plan:
- LD_IFM1, base 0x10, len 3, data A,B,C with a 1-cycle in_valid gap → three writes at 0x10/0x11/0x12.
  - dla_ifm1_w_en=0 only on the beat cycles; ifm0_w_en stays F; busy drops the cycle after C.
- CFG with words 0xDEAD0001, 0x00000042 → config_w_en 001 then 010; w_addr 0 then 1.
- WAIT_INT, dla_inpt raised after 20 cycles → one cycle of config_w_en=100 with w_data=0, then IDLE; cmd_ready=1 on the next cycle.
- RD_OUT, base 0x800, len 4, RD_LAT=1, dla_r_data model = addr^0x5A5A.
  - out_ready toggled 1/0 → four beats, each equal to the model.
  - out_data stable while stalled; r_addr sequence 0x800..0x803.
- Reset asserted during RD_HOLD with out_valid=1 → out_valid=0 and state IDLE with no clock edge; the next command executes normally.
- cmd_op=7 → cmd_err one-cycle pulse, no DLA enables asserted. LD_WEIGHT with len 0 → no weight_w_en.

Source files
------------

// File: rtl/dla_host_seq_pkg.sv
// dla_host_pkg: shared types and constants for the DLA host sequencer.
//   cmd_op_e  - command opcodes accepted from the CPU-side wrapper
//   state_e   - sequencer FSM states
//   *_WEN_*   - idle / active patterns for the DLA write-enable groups
package dla_host_pkg;

  typedef enum logic [2:0] {
    OP_LD_WEIGHT = 3'd0,
    OP_LD_IFM0   = 3'd1,
    OP_LD_IFM1   = 3'd2,
    OP_CFG       = 3'd3,
    OP_WAIT_INT  = 3'd4,
    OP_RD_OUT    = 3'd5,
    OP_RSV6      = 3'd6,
    OP_RSV7      = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_HOLD  = 3'd4,
    ST_WAIT_INT = 3'd5,
    ST_CLR_INT  = 3'd6
  } state_e;

  localparam logic [3:0] IFM_WEN_IDLE = 4'hF;  // ifm enables are active low
  localparam logic [3:0] IFM_WEN_ALL  = 4'h0;
  localparam logic [3:0] WEI_WEN_ALL  = 4'hF;  // weight enables are active high
  localparam logic [2:0] CFG_WEN_INPT = 3'b100;

  // Ops that stream payload words into the DLA and honour cmd_len.
  function automatic logic is_load(cmd_op_e op);
    return (op == OP_LD_WEIGHT) || (op == OP_LD_IFM0) || (op == OP_LD_IFM1);
  endfunction

endpackage

// File: rtl/dla_host_seq_if.sv
// dla_host_seq_if: host-side streams of the DLA sequencer.
//   cmd_*  - command request (valid/ready), opcode, base address, word count
//   in_*   - write payload stream into the sequencer
//   out_*  - read-back stream out of the sequencer
// master = CPU-side wrapper / DMA, slave = dla_host_seq.
interface dla_host_seq_if #(
  parameter int BW    = 32,
  parameter int LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [BW-1:0]    cmd_base;
  logic [LEN_W-1:0] cmd_len;

  logic             in_valid;
  logic             in_ready;
  logic [BW-1:0]    in_data;

  logic             out_valid;
  logic             out_ready;
  logic [BW-1:0]    out_data;

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_len, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_len, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dla_host_seq_rd_lat.sv
// dla_rd_lat_cnt: read-latency timer and capture register for the read path.
//   start   - read address issued this cycle; arms the counter
//   wait_en - sequencer is waiting on the DLA read data
//   r_data  - DLA read data
//   done    - last wait cycle; r_data is valid and captured at this edge
//   data    - captured read word (held until the next capture)
module dla_rd_lat_cnt #(
  parameter int BW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          wait_en,
  input  logic [BW-1:0] r_data,
  output logic          done,
  output logic [BW-1:0] data
);
  // RD_LAT is 1..3, so a 2-bit down-counter covers it.
  logic [1:0]    cnt_q, cnt_d;
  logic [BW-1:0] data_q, data_d;

  assign done = wait_en && (cnt_q == 2'd0);
  assign data = data_q;

  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    if (start)                         cnt_d = 2'(RD_LAT - 1);
    else if (wait_en && cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
    if (done)                          data_d = r_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/dla_host_seq.sv
// dla_host_seq: initiator-side sequencer driving the DLA memory-mapped ports.
//   clk, rst          - DLA clock, async active-high reset
//   host              - cmd / write-payload / read-back streams (slave side)
//   dla_w_addr/data   - DLA write address and data
//   dla_*_w_en        - write-enable groups (ifm active low, weight/config high)
//   dla_r_addr/data   - DLA read address and returned data
//   dla_inpt          - DLA interrupt level
//   busy, cmd_err     - status: not idle / reserved-op pulse
module dla_host_seq
  import dla_host_pkg::*;
#(
  parameter int BW     = 32,
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  dla_host_seq_if.slave host,
  output logic [BW-1:0] dla_w_addr,
  output logic [BW-1:0] dla_w_data,
  output logic [BW-1:0] dla_r_addr,
  output logic [2:0]    dla_config_w_en,
  output logic [3:0]    dla_ifm0_w_en,
  output logic [3:0]    dla_ifm1_w_en,
  output logic [3:0]    dla_weight_w_en,
  input  logic [BW-1:0] dla_r_data,
  input  logic          dla_inpt,
  output logic          busy,
  output logic          cmd_err
);
  state_e           state_q, state_d;
  cmd_op_e          op_q, op_d, acc_op;
  logic [BW-1:0]    addr_q, addr_d;
  logic [BW-1:0]    r_addr_q, r_addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic             lat_done;
  logic             beat;

  assign acc_op = cmd_op_e'(host.cmd_op);

  assign host.cmd_ready = (state_q == ST_IDLE);
  assign host.in_ready  = (state_q == ST_WRITE);
  // Derived from state so an async reset drops it without a clock edge.
  assign host.out_valid = (state_q == ST_RD_HOLD);
  assign busy           = (state_q != ST_IDLE);
  assign cmd_err        = err_q;
  assign beat           = (state_q == ST_WRITE) && host.in_valid;

  // Read address is shown live in RD_ISSUE and held afterwards.
  assign dla_r_addr = (state_q == ST_RD_ISSUE) ? addr_q : r_addr_q;

  dla_rd_lat_cnt #(.BW(BW), .RD_LAT(RD_LAT)) u_rd_lat (
    .clk     (clk),
    .rst     (rst),
    .start   (state_q == ST_RD_ISSUE),
    .wait_en (state_q == ST_RD_WAIT),
    .r_data  (dla_r_data),
    .done    (lat_done),
    .data    (host.out_data)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    r_addr_d = r_addr_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: if (host.cmd_valid) begin
        op_d   = acc_op;
        addr_d = host.cmd_base;
        rem_d  = host.cmd_len;
        case (acc_op)
          OP_LD_WEIGHT, OP_LD_IFM0, OP_LD_IFM1:
            if (host.cmd_len != '0) state_d = ST_WRITE;
          OP_CFG: begin
            // Two op_config words; the address register doubles as word index.
            addr_d  = '0;
            rem_d   = LEN_W'(2);
            state_d = ST_WRITE;
          end
          OP_WAIT_INT: state_d = ST_WAIT_INT;
          OP_RD_OUT:   if (host.cmd_len != '0) state_d = ST_RD_ISSUE;
          default:     err_d = 1'b1;
        endcase
      end
      ST_WRITE: if (host.in_valid) begin
        addr_d = addr_q + BW'(1);
        rem_d  = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) state_d = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        r_addr_d = addr_q;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (lat_done) state_d = ST_RD_HOLD;
      ST_RD_HOLD: if (host.out_ready) begin
        addr_d  = addr_q + BW'(1);
        rem_d   = rem_q - LEN_W'(1);
        state_d = (rem_q == LEN_W'(1)) ? ST_IDLE : ST_RD_ISSUE;
      end
      ST_WAIT_INT: if (dla_inpt) state_d = ST_CLR_INT;
      ST_CLR_INT:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // DLA write port: everything idles unless a beat or the interrupt clear.
  always_comb begin
    dla_w_addr      = '0;
    dla_w_data      = '0;
    dla_config_w_en = 3'b000;
    dla_ifm0_w_en   = IFM_WEN_IDLE;
    dla_ifm1_w_en   = IFM_WEN_IDLE;
    dla_weight_w_en = 4'h0;
    if (beat) begin
      dla_w_addr = addr_q;
      dla_w_data = host.in_data;
      case (op_q)
        OP_LD_WEIGHT: dla_weight_w_en = WEI_WEN_ALL;
        OP_LD_IFM0:   dla_ifm0_w_en   = IFM_WEN_ALL;
        OP_LD_IFM1:   dla_ifm1_w_en   = IFM_WEN_ALL;
        OP_CFG:       dla_config_w_en = addr_q[0] ? 3'b010 : 3'b001;
        default:      ;
      endcase
    end else if (state_q == ST_CLR_INT) begin
      dla_config_w_en = CFG_WEN_INPT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LD_WEIGHT;
      addr_q   <= '0;
      rem_q    <= '0;
      r_addr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      r_addr_q <= r_addr_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_dla_host_seq.sv
module tb_dla_host_seq;
  localparam int BW     = 32;
  localparam int LEN_W  = 16;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] dla_w_addr, dla_w_data, dla_r_addr, dla_r_data;
  logic [2:0]    dla_config_w_en;
  logic [3:0]    dla_ifm0_w_en, dla_ifm1_w_en, dla_weight_w_en;
  logic          dla_inpt = 1'b0;
  logic          busy, cmd_err;

  dla_host_seq_if #(.BW(BW), .LEN_W(LEN_W)) hif ();

  dla_host_seq #(.BW(BW), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .host(hif),
    .dla_w_addr(dla_w_addr), .dla_w_data(dla_w_data), .dla_r_addr(dla_r_addr),
    .dla_config_w_en(dla_config_w_en), .dla_ifm0_w_en(dla_ifm0_w_en),
    .dla_ifm1_w_en(dla_ifm1_w_en), .dla_weight_w_en(dla_weight_w_en),
    .dla_r_data(dla_r_data), .dla_inpt(dla_inpt), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // DLA read model: data = addr ^ 0x5A5A, RD_LAT registered stages.
  logic [BW-1:0] r_pipe [RD_LAT];
  always @(posedge clk) begin
    r_pipe[0] <= dla_r_addr ^ 32'h5A5A;
    for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
  end
  assign dla_r_data = r_pipe[RD_LAT-1];

  int ncmp = 0, nfail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- write scoreboard ----------------
  typedef struct {
    logic [14:0]   wen;   // {config, weight, ifm1, ifm0}
    logic [31:0]   addr;
    logic [31:0]   data;
    bit            chk_addr;
  } wr_t;
  wr_t wq[$];

  always @(negedge clk) begin : mon_wr
    wr_t e;
    if (!rst && (dla_config_w_en != 3'b000 || dla_weight_w_en != 4'h0 ||
                 dla_ifm0_w_en != 4'hF || dla_ifm1_w_en != 4'hF)) begin
      if (wq.size() == 0) begin
        ncmp++; nfail++;
        $display("FAIL unexpected_write: wen %h addr %h data %h, none expected",
                 {dla_config_w_en, dla_weight_w_en, dla_ifm1_w_en, dla_ifm0_w_en},
                 dla_w_addr, dla_w_data);
      end else begin
        e = wq.pop_front();
        chk("wr_wen", 32'({dla_config_w_en, dla_weight_w_en, dla_ifm1_w_en, dla_ifm0_w_en}),
            32'(e.wen));
        chk("wr_data", dla_w_data, e.data);
        if (e.chk_addr) chk("wr_addr", dla_w_addr, e.addr);
      end
    end
  end

  // ---------------- read scoreboard ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } rd_t;
  rd_t rq[$];
  logic [31:0] hold_data;
  bit          hold_vld = 0;
  bit          tput_on  = 0;
  int          last_hs  = -1;

  always @(negedge clk) begin : mon_rd
    rd_t e;
    if (rst) hold_vld = 0;
    else begin
      if (hif.out_valid && hold_vld) chk("out_stable", hif.out_data, hold_data);
      if (hif.out_valid && hif.out_ready) begin
        if (rq.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL unexpected_read: got %h, none expected", hif.out_data);
        end else begin
          e = rq.pop_front();
          chk("rd_data", hif.out_data, e.data);
          chk("rd_addr", dla_r_addr, e.addr);
        end
        if (tput_on && last_hs >= 0) chk("rd_tput", 32'(cyc - last_hs), 32'(RD_LAT + 2));
        last_hs = cyc;
      end
      hold_vld  = hif.out_valid && !hif.out_ready;
      hold_data = hif.out_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(logic [2:0] op, logic [31:0] base, logic [15:0] len);
    int n = 0;
    hif.cmd_op = op; hif.cmd_base = base; hif.cmd_len = len; hif.cmd_valid = 1'b1;
    while (!hif.cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!hif.cmd_ready) begin ncmp++; nfail++; $display("FAIL cmd_timeout: cmd_ready 0 expected 1"); end
    @(posedge clk); #1;
    hif.cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] base;
    logic [15:0] len;
    int          nbeats;
    bit          exp_err;
    logic [3:0]  wei, ifm1, ifm0;
  } vec_t;

  logic [31:0] cfg_words [2];

  task automatic run_vec(vec_t v);
    int  k = 0, budget = 0;
    bit  gapped = 0, hs;
    wr_t e;
    issue(v.op, v.base, v.len);
    chk("cmd_err_pulse", 32'(cmd_err), 32'(v.exp_err));
    while (k < v.nbeats && budget < 200) begin
      if (k == 1 && !gapped) begin
        hif.in_valid = 1'b0; gapped = 1;
      end else begin
        hif.in_valid = 1'b1;
        hif.in_data  = (v.op == 3'd3) ? cfg_words[k] : $urandom;
      end
      hs = hif.in_valid && hif.in_ready;
      if (hs) begin
        e.wen      = (v.op == 3'd3) ? {3'(1 << k), 4'h0, 4'hF, 4'hF} : {3'b000, v.wei, v.ifm1, v.ifm0};
        e.addr     = (v.op == 3'd3) ? 32'(k) : v.base + 32'(k);
        e.data     = hif.in_data;
        e.chk_addr = 1;
        wq.push_back(e);
      end
      @(posedge clk); #1;
      if (hs) k++;
      budget++;
    end
    hif.in_valid = 1'b0;
    if (k != v.nbeats) begin ncmp++; nfail++; $display("FAIL beat_timeout: %0d beats expected %0d", k, v.nbeats); end
    chk("busy_after", 32'(busy), 32'd0);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    @(posedge clk); #1;
    chk("cmd_err_clear", 32'(cmd_err), 32'd0);
  endtask

  task automatic run_read(logic [31:0] base, logic [15:0] len, bit toggle);
    int n = 0;
    rd_t e;
    for (int k = 0; k < int'(len); k++) begin
      e.addr = base + 32'(k);
      e.data = (base + 32'(k)) ^ 32'h5A5A;
      rq.push_back(e);
    end
    last_hs = -1; tput_on = !toggle; hif.out_ready = 1'b1;
    issue(3'd5, base, len);
    while (busy && n < 300) begin
      if (toggle) hif.out_ready = ~hif.out_ready;
      @(posedge clk); #1; n++;
    end
    chk("rd_done", 32'(busy), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    tput_on = 0; hif.out_ready = 1'b1;
  endtask

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running");
    $fatal(1, "timeout");
  end

  initial begin
    cfg_words[0] = 32'hDEAD0001;
    cfg_words[1] = 32'h00000042;
    //           op    base          len     nb err wei   ifm1  ifm0
    vecs[0] = '{3'd2, 32'h10,       16'd3,  3, 0, 4'h0, 4'h0, 4'hF};
    vecs[1] = '{3'd3, 32'h1234,     16'd9,  2, 0, 4'h0, 4'hF, 4'hF};
    vecs[2] = '{3'd0, 32'h40,       16'd0,  0, 0, 4'h0, 4'hF, 4'hF};
    vecs[3] = '{3'd7, 32'h0,        16'd4,  0, 1, 4'h0, 4'hF, 4'hF};
    vecs[4] = '{3'd1, 32'hFFFFFFFE, 16'd3,  3, 0, 4'h0, 4'hF, 4'h0};
    vecs[5] = '{3'd0, 32'h100,      16'd4,  4, 0, 4'hF, 4'hF, 4'hF};
    vecs[6] = '{3'd6, 32'h0,        16'd5,  0, 1, 4'h0, 4'hF, 4'hF};
    vecs[7] = '{3'd5, 32'h500,      16'd0,  0, 0, 4'h0, 4'hF, 4'hF};

    hif.cmd_valid = 0; hif.cmd_op = 0; hif.cmd_base = 0; hif.cmd_len = 0;
    hif.in_valid = 0; hif.in_data = 0; hif.out_ready = 1;

    // Reset values
    repeat (2) @(posedge clk); #1;
    chk("rst_w_addr", dla_w_addr, 32'h0);
    chk("rst_w_data", dla_w_data, 32'h0);
    chk("rst_r_addr", dla_r_addr, 32'h0);
    chk("rst_wen", 32'({dla_config_w_en, dla_weight_w_en, dla_ifm1_w_en, dla_ifm0_w_en}),
        32'({3'b000, 4'h0, 4'hF, 4'hF}));
    chk("rst_status", 32'({hif.out_valid, hif.in_ready, busy, cmd_err}), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_cmd_ready", 32'(hif.cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // WAIT_INT: interrupt after 20 cycles, one clear write, then idle
    begin
      wr_t e;
      issue(3'd4, 32'h0, 16'd0);
      repeat (20) @(posedge clk);
      #1;
      chk("wait_busy", 32'(busy), 32'd1);
      dla_inpt = 1'b1;
      e.wen = {3'b100, 4'h0, 4'hF, 4'hF}; e.addr = 0; e.data = 0; e.chk_addr = 0;
      wq.push_back(e);
      @(posedge clk); #1;
      dla_inpt = 1'b0;
      chk("clr_cmd_ready", 32'(hif.cmd_ready), 32'd0);
      @(posedge clk); #1;
      chk("post_clr_ready", 32'(hif.cmd_ready), 32'd1);
      chk("clr_wq_drained", 32'(wq.size()), 32'd0);
    end

    run_read(32'h800, 16'd4, 1);      // out_ready toggling
    run_read(32'h900, 16'd3, 0);      // out_ready held high: throughput

    // Reset during RD_HOLD
    begin
      int n = 0;
      hif.out_ready = 1'b0;
      issue(3'd5, 32'h200, 16'd4);
      while (!hif.out_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("pre_rst_valid", 32'(hif.out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_valid", 32'(hif.out_valid), 32'd0);
      chk("rst_async_busy", 32'(busy), 32'd0);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      hif.out_ready = 1'b1;
      run_read(32'h300, 16'd2, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
